eu: RTL and testbench
=====================

EU -- requirements
Module: eu

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 A  input  16  operand A, unsigned.
REQ-004 B  input  16  operand B, unsigned.
REQ-005 Ci  input  1  carry-in for add, borrow-in for subtract; ignored otherwise.
REQ-006 f0  input  2  function select: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-007 rd  input  4  destination register index, 0..15.
REQ-008 x0..x15  output  16 each  contents of register file entries 0..15.
REQ-009 One clock, clk; reset rst is synchronous and active-high; no other clocks, enables or handshake ports.

Function
REQ-010 Sixteen 16-bit registers R0..R15 SHALL be held internally; xN SHALL drive RN directly, with no combinational path from inputs to outputs.
REQ-011 Every rising clk edge with rst=0 SHALL write the selected result Y into R[rd]; all other registers SHALL hold.
REQ-012 Every register, including R0, SHALL be writable; there is no hard-wired zero register.
REQ-013 Latency: operands sampled at edge k SHALL be visible on x[rd] immediately after edge k (one cycle, 1 write per cycle).
REQ-014 f0=00: Y = (A + B + Ci) mod 2^16; carry-out discarded.
REQ-015 f0=01: Y = (A - B - Ci) mod 2^16 (two's-complement wrap); borrow-out discarded.
REQ-016 f0=10: Y = A[7:0] * B[7:0] as full unsigned 16-bit product; A[15:8], B[15:8] ignored; never overflows.
REQ-017 f0=11: Y = floor(A / B), 16-bit unsigned quotient; remainder discarded.
REQ-018 Divide by zero (f0=11, B=0): Y SHALL be 16'hFFFF.
REQ-019 All four results SHALL be computed combinationally within one clock period; no multicycle operation or busy state.
REQ-020 Same rd on consecutive cycles: later write SHALL overwrite earlier; no accumulation.
REQ-021 X/Z-free inputs are required; behaviour with unknown inputs is unspecified.

Reset
REQ-022 rst=1 at a rising edge SHALL clear R0..R15 to 16'h0000, taking priority over any write that cycle.
REQ-023 rst asserted mid-sequence SHALL discard the pending write; after rst falls, the next edge SHALL resume normal writes.
REQ-024 Before the first reset edge, register contents are undefined; benches SHALL apply reset for at least one edge.

Verification
REQ-025 Reset: rst=1 one edge -> x0..x15 all 16'h0000.
REQ-026 Add: f0=00, A=16'hFFFF, B=16'h0001, Ci=1, rd=3 -> after edge x3=16'h0001, all others unchanged.
REQ-027 Subtract: f0=01, A=16'h0005, B=16'h0007, Ci=1, rd=15 -> x15=16'hFFFD.
REQ-028 Multiply: f0=10, A=16'h12FF, B=16'hABFF, rd=0 -> x0=16'hFE01.
REQ-029 Divide: f0=11, A=100, B=7, rd=9 -> x9=14; then B=0, rd=9 -> x9=16'hFFFF.
REQ-030 Random: 1000 cycles of random A, B, Ci, f0, rd checked against reference model per REQ-014..018; one-hot write check (only x[rd] may change); rst pulsed randomly -> all zero.

Source files
------------

// File: rtl/eu.sv
// Execution unit: one add/sub/mul/div result per cycle, written into a 16-entry register file.
// All arithmetic is single-cycle combinational; the register file is the only state.
module eu (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Ci,
  input  logic [1:0]  f0,
  input  logic [3:0]  rd,
  output logic [15:0] x0,
  output logic [15:0] x1,
  output logic [15:0] x2,
  output logic [15:0] x3,
  output logic [15:0] x4,
  output logic [15:0] x5,
  output logic [15:0] x6,
  output logic [15:0] x7,
  output logic [15:0] x8,
  output logic [15:0] x9,
  output logic [15:0] x10,
  output logic [15:0] x11,
  output logic [15:0] x12,
  output logic [15:0] x13,
  output logic [15:0] x14,
  output logic [15:0] x15
);

  typedef enum logic [1:0] {
    FnAdd = 2'b00,
    FnSub = 2'b01,
    FnMul = 2'b10,
    FnDiv = 2'b11
  } fn_e;

  logic [15:0] regs_q [16];
  logic [15:0] y;
  logic [15:0] ci_ext;
  logic [15:0] a_lo;
  logic [15:0] b_lo;

  assign ci_ext = {15'b0, Ci};
  assign a_lo   = {8'b0, A[7:0]};
  assign b_lo   = {8'b0, B[7:0]};

  always_comb begin
    y = '0;
    unique case (fn_e'(f0))
      FnAdd: y = A + B + ci_ext;
      FnSub: y = A - B - ci_ext;
      // 8x8 product always fits in 16 bits
      FnMul: y = a_lo * b_lo;
      FnDiv: y = (B == 16'h0000) ? 16'hFFFF : A / B;
      default: y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q[rd] <= y;
    end
  end

  assign x0  = regs_q[0];
  assign x1  = regs_q[1];
  assign x2  = regs_q[2];
  assign x3  = regs_q[3];
  assign x4  = regs_q[4];
  assign x5  = regs_q[5];
  assign x6  = regs_q[6];
  assign x7  = regs_q[7];
  assign x8  = regs_q[8];
  assign x9  = regs_q[9];
  assign x10 = regs_q[10];
  assign x11 = regs_q[11];
  assign x12 = regs_q[12];
  assign x13 = regs_q[13];
  assign x14 = regs_q[14];
  assign x15 = regs_q[15];

endmodule

// File: tb/tb_eu.sv
// Bench for eu: hand-computed vector table, reset/latency corner sequences, then a randomised run
// against a small reference model with a full register-file check every cycle.
module tb_eu;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Ci;
  logic [1:0]  f0;
  logic [3:0]  rd;
  logic [15:0] x0, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12, x13, x14, x15;

  logic [15:0] xs [16];
  logic [15:0] model [16];

  int n_chk;
  int n_fail;

  eu dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Ci(Ci), .f0(f0), .rd(rd),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .x8(x8), .x9(x9), .x10(x10), .x11(x11), .x12(x12), .x13(x13), .x14(x14), .x15(x15)
  );

  assign xs[0]  = x0;
  assign xs[1]  = x1;
  assign xs[2]  = x2;
  assign xs[3]  = x3;
  assign xs[4]  = x4;
  assign xs[5]  = x5;
  assign xs[6]  = x6;
  assign xs[7]  = x7;
  assign xs[8]  = x8;
  assign xs[9]  = x9;
  assign xs[10] = x10;
  assign xs[11] = x11;
  assign xs[12] = x12;
  assign xs[13] = x13;
  assign xs[14] = x14;
  assign xs[15] = x15;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [1:0]  f;
    logic [3:0]  rd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s x%0d", tag, i), xs[i], model[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_y(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic [1:0] f);
    logic [31:0] t;
    case (f)
      2'b00: t = 32'(a) + 32'(b) + 32'(ci);
      2'b01: t = 32'(a) - 32'(b) - 32'(ci);
      2'b10: t = 32'(a[7:0]) * 32'(b[7:0]);
      default: t = (b == 16'h0) ? 32'hFFFF : 32'(a) / 32'(b);
    endcase
    return t[15:0];
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b1; A = '0; B = '0; Ci = 1'b0; f0 = 2'b00; rd = '0;

    vecs[0]  = '{"add wrap",      16'hFFFF, 16'h0001, 1'b1, 2'b00, 4'd3,  16'h0001};
    vecs[1]  = '{"sub wrap",      16'h0005, 16'h0007, 1'b1, 2'b01, 4'd15, 16'hFFFD};
    vecs[2]  = '{"mul low bytes", 16'h12FF, 16'hABFF, 1'b0, 2'b10, 4'd0,  16'hFE01};
    vecs[3]  = '{"div 100/7",     16'd100,  16'd7,    1'b0, 2'b11, 4'd9,  16'd14};
    vecs[4]  = '{"div by zero",   16'd100,  16'd0,    1'b0, 2'b11, 4'd9,  16'hFFFF};
    vecs[5]  = '{"add plain",     16'h1234, 16'h4321, 1'b0, 2'b00, 4'd1,  16'h5555};
    vecs[6]  = '{"sub 0-0-1",     16'h0000, 16'h0000, 1'b1, 2'b01, 4'd2,  16'hFFFF};
    vecs[7]  = '{"mul 16*16",     16'h0010, 16'h0010, 1'b0, 2'b10, 4'd4,  16'h0100};
    vecs[8]  = '{"div by one",    16'hFFFF, 16'h0001, 1'b0, 2'b11, 4'd5,  16'hFFFF};
    vecs[9]  = '{"div small",     16'd7,    16'd100,  1'b0, 2'b11, 4'd6,  16'd0};
    vecs[10] = '{"same rd first", 16'd1,    16'd1,    1'b0, 2'b00, 4'd7,  16'd2};
    vecs[11] = '{"same rd again", 16'd3,    16'd0,    1'b0, 2'b00, 4'd7,  16'd3};
    vecs[12] = '{"sub no borrow", 16'h8000, 16'h0001, 1'b0, 2'b01, 4'd8,  16'h7FFF};
    vecs[13] = '{"mul ignores ci",16'h0003, 16'h0005, 1'b1, 2'b10, 4'd10, 16'h000F};
    vecs[14] = '{"div ignores ci",16'd9,    16'd3,    1'b1, 2'b11, 4'd11, 16'd3};

    // Reset for one edge clears everything
    step();
    for (int i = 0; i < 16; i++) model[i] = '0;
    check_all("reset");
    rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      A = vecs[v].a; B = vecs[v].b; Ci = vecs[v].ci; f0 = vecs[v].f; rd = vecs[v].rd;
      // No combinational path: outputs must not move before the edge
      #1;
      check_all({vecs[v].name, " pre-edge"});
      step();
      model[vecs[v].rd] = vecs[v].exp;
      check_all(vecs[v].name);
    end

    // Reset with a write pending: write discarded, all zero
    A = 16'h0001; B = 16'h0001; Ci = 1'b0; f0 = 2'b00; rd = 4'd12; rst = 1'b1;
    step();
    for (int i = 0; i < 16; i++) model[i] = '0;
    check_all("reset over write");
    rst = 1'b0;
    step();
    model[12] = 16'h0002;
    check_all("resume after reset");

    // Random run
    for (int c = 0; c < 1000; c++) begin
      A  = 16'($urandom);
      B  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      Ci = 1'($urandom);
      f0 = 2'($urandom);
      rd = 4'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      step();
      if (rst) begin
        for (int i = 0; i < 16; i++) model[i] = '0;
      end else begin
        model[rd] = ref_y(A, B, Ci, f0);
      end
      check_all($sformatf("rand %0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
